// File: rtl/system_interconnect_if.sv
// Bus bundle between the upstream master, the interconnect and its slave ports.
// The interconnect plugs into the slave modport; the environment that plays the
// master and all slaves plugs into the master modport.
interface system_interconnect_if #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int BE = DATA_WIDTH / 8;

  // Upstream master side
  logic                           ready;
  logic [31:0]                    addr;
  logic [DATA_WIDTH-1:0]          write_data;
  logic [BE-1:0]                  byte_enable;
  logic                           write_req;
  logic                           read_req;
  logic [DATA_WIDTH-1:0]          read_data;
  logic                           read_data_valid;
  logic                           decode_error;
  logic                           stray_response;

  // Downstream slave ports, packed slave-major
  logic [NUM_SLAVES-1:0]            s_ready;
  logic [NUM_SLAVES*32-1:0]         s_addr;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_write_data;
  logic [NUM_SLAVES*BE-1:0]         s_byte_enable;
  logic [NUM_SLAVES-1:0]            s_write_req;
  logic [NUM_SLAVES-1:0]            s_read_req;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_read_data;
  logic [NUM_SLAVES-1:0]            s_read_data_valid;

  // Environment view: drives requests and slave responses
  modport master (
    output addr, write_data, byte_enable, write_req, read_req,
    output s_ready, s_read_data, s_read_data_valid,
    input  ready, read_data, read_data_valid, decode_error, stray_response,
    input  s_addr, s_write_data, s_byte_enable, s_write_req, s_read_req
  );

  // Interconnect view
  modport slave (
    input  addr, write_data, byte_enable, write_req, read_req,
    input  s_ready, s_read_data, s_read_data_valid,
    output ready, read_data, read_data_valid, decode_error, stray_response,
    output s_addr, s_write_data, s_byte_enable, s_write_req, s_read_req
  );
endinterface

// File: rtl/system_interconnect.sv
// Single-master, multi-slave address-decoding interconnect.
// Requests are routed by the top address nibble; reads are returned to the
// master strictly in issue order using a small FIFO of target IDs. Responses a
// slave sends out of turn are dropped and latched as a sticky stray flag.
module system_interconnect #(
  parameter int                    NUM_SLAVES    = 4,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    MAX_READS     = 4,
  parameter logic [31:0]           SLAVE_TAGS    = 32'h0000_4321,
  parameter logic [DATA_WIDTH-1:0] UNMAPPED_DATA = '0
) (
  input logic                  clk,
  input logic                  reset_n,
  system_interconnect_if.slave io_bus
);

  localparam int ID_W  = $clog2(NUM_SLAVES + 1);
  localparam int PTR_W = $clog2(MAX_READS);
  localparam int CNT_W = $clog2(MAX_READS + 1);
  localparam logic [ID_W-1:0]  UNMAPPED_ID = ID_W'(NUM_SLAVES);
  localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(MAX_READS);

  // Read-order tracking FIFO
  logic [ID_W-1:0]  r_fifo [MAX_READS];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_stray;

  // Decode results
  logic                  w_hit;
  logic [NUM_SLAVES-1:0] w_hit_vec;
  logic [ID_W-1:0]       w_hit_id;

  // Request path
  logic w_full;
  logic w_empty;
  logic w_ready;
  logic w_accept;
  logic w_read_only;
  logic w_push;

  // Return path
  logic [ID_W-1:0]       w_head_id;
  logic                  w_sel_valid;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_stray_evt;

  // Address decode: lowest-index slave whose tag matches wins
  always_comb begin
    w_hit     = 1'b0;
    w_hit_vec = '0;
    w_hit_id  = UNMAPPED_ID;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (SLAVE_TAGS[4*i +: 4] == io_bus.addr[31:28]) begin
        w_hit        = 1'b1;
        w_hit_vec    = '0;
        w_hit_vec[i] = 1'b1;
        w_hit_id     = ID_W'(i);
      end else begin
        w_hit = w_hit;
      end
    end
  end

  assign w_full      = (r_count == FULL_COUNT);
  assign w_empty     = (r_count == '0);
  assign w_head_id   = r_fifo[r_rd_ptr];

  // Master-facing ready: unmapped targets always accept unless tracking is full
  always_comb begin
    w_ready = 1'b0;
    if (reset_n && !w_full) begin
      if (w_hit) begin
        w_ready = |(w_hit_vec & io_bus.s_ready);
      end else begin
        w_ready = 1'b1;
      end
    end else begin
      w_ready = 1'b0;
    end
  end

  assign w_accept    = (io_bus.read_req | io_bus.write_req) & w_ready;
  // A combined write+read forwards only the write; the read is dropped
  assign w_read_only = io_bus.read_req & ~io_bus.write_req;
  assign w_push      = w_accept & w_read_only;

  // Head-of-FIFO response selection among the slave return ports
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (w_head_id == ID_W'(i)) begin
        w_sel_valid = io_bus.s_read_data_valid[i];
        w_sel_data  = io_bus.s_read_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        w_sel_valid = w_sel_valid;
      end
    end
  end

  // In-order return: unmapped head completes immediately, mapped head waits for its slave
  always_comb begin
    w_pop     = 1'b0;
    w_rd_data = '0;
    if (reset_n && !w_empty) begin
      if (w_head_id == UNMAPPED_ID) begin
        w_pop     = 1'b1;
        w_rd_data = UNMAPPED_DATA;
      end else if (w_sel_valid) begin
        w_pop     = 1'b1;
        w_rd_data = w_sel_data;
      end else begin
        w_pop     = 1'b0;
        w_rd_data = '0;
      end
    end else begin
      w_pop     = 1'b0;
      w_rd_data = '0;
    end
  end

  // Stray detection: any return that does not belong to the current head
  always_comb begin
    w_stray_evt = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (io_bus.s_read_data_valid[i] && (w_empty || (w_head_id != ID_W'(i)))) begin
        w_stray_evt = 1'b1;
      end else begin
        w_stray_evt = w_stray_evt;
      end
    end
  end

  // Tracking FIFO, occupancy counter and sticky stray flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_READS; i++) begin
        r_fifo[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_stray  <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_hit_id;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_stray_evt) begin
        r_stray <= 1'b1;
      end
    end
  end

  // Slave-side drive: address with the routing nibble stripped, broadcast write data
  assign io_bus.s_addr        = {NUM_SLAVES{{4'h0, io_bus.addr[27:0]}}};
  assign io_bus.s_write_data  = {NUM_SLAVES{io_bus.write_data}};
  assign io_bus.s_byte_enable = {NUM_SLAVES{io_bus.byte_enable}};
  assign io_bus.s_write_req   = w_hit_vec & {NUM_SLAVES{w_accept & io_bus.write_req}};
  assign io_bus.s_read_req    = w_hit_vec & {NUM_SLAVES{w_accept & w_read_only}};

  // Master-side outputs
  assign io_bus.ready           = w_ready;
  assign io_bus.read_data_valid = w_pop;
  assign io_bus.read_data       = w_rd_data;
  assign io_bus.decode_error    = w_accept & ~w_hit;
  assign io_bus.stray_response  = r_stray;

endmodule

// File: tb/tb_system_interconnect.sv
// Self-checking bench for system_interconnect: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic checked every cycle against a
// queue-based reference model of the in-order read return rules.
module tb_system_interconnect;

  localparam int          NS    = 4;
  localparam int          DW    = 32;
  localparam int          MAXR  = 4;
  localparam logic [31:0] TAGS  = 32'h0000_4321;
  localparam logic [31:0] UNMAP = 32'hBAD0_CAFE;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  system_interconnect_if #(.NUM_SLAVES(NS), .DATA_WIDTH(DW)) bus ();

  system_interconnect #(
    .NUM_SLAVES(NS), .DATA_WIDTH(DW), .MAX_READS(MAXR),
    .SLAVE_TAGS(TAGS), .UNMAPPED_DATA(UNMAP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .io_bus(bus.slave)
  );

  // ---------------- reference model ----------------
  int q[$];          // outstanding read targets, oldest first (NS = unmapped)
  bit m_stray = 1'b0;
  bit p_pop, p_push, p_stray;
  int p_tgt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    logic [31:0] tags;
    tags = TAGS;
    for (int i = 0; i < NS; i++) begin
      if (tags[4*i +: 4] == a[31:28]) return i;
    end
    return NS;
  endfunction

  // Evaluate the expected outputs for the current inputs and compare
  task automatic model_check();
    int t;
    bit er, acc, ed, ev, es;
    logic [NS-1:0] ews, ers;
    logic [DW-1:0] erd;
    t = decode(bus.addr);
    er = 0; acc = 0; ed = 0; ev = 0; es = 0; ews = '0; ers = '0; erd = '0;
    if (reset_n) begin
      if (q.size() < MAXR) er = (t == NS) ? 1'b1 : bus.s_ready[t];
      acc = (bus.read_req || bus.write_req) && er;
      if (acc && t < NS) begin
        if (bus.write_req) ews[t] = 1'b1;
        else ers[t] = 1'b1;
      end
      ed = acc && (t == NS);
      if (q.size() > 0) begin
        if (q[0] == NS) begin
          ev = 1; erd = UNMAP;
        end else if (bus.s_read_data_valid[q[0]]) begin
          ev = 1; erd = bus.s_read_data[q[0]*DW +: DW];
        end
      end
      for (int j = 0; j < NS; j++) begin
        if (bus.s_read_data_valid[j] && (q.size() == 0 || q[0] != j)) es = 1;
      end
    end
    chk("m_ready", bus.ready, er);
    chk("m_s_write_req", bus.s_write_req, ews);
    chk("m_s_read_req", bus.s_read_req, ers);
    chk("m_decode_error", bus.decode_error, ed);
    chk("m_read_data_valid", bus.read_data_valid, ev);
    chk("m_read_data", bus.read_data, erd);
    chk("m_stray_response", bus.stray_response, m_stray);
    chk("m_s_addr", bus.s_addr, {NS{{4'h0, bus.addr[27:0]}}});
    chk("m_s_write_data", bus.s_write_data, {NS{bus.write_data}});
    chk("m_s_byte_enable", bus.s_byte_enable, {NS{bus.byte_enable}});
    p_pop = ev; p_push = acc && bus.read_req && !bus.write_req; p_tgt = t; p_stray = es;
  endtask

  task automatic model_update();
    if (!reset_n) begin
      q.delete();
      m_stray = 1'b0;
    end else begin
      if (p_pop) void'(q.pop_front());
      if (p_push) q.push_back(p_tgt);
      if (p_stray) m_stray = 1'b1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [31:0] a, input bit wr, input bit rd, input logic [NS-1:0] srdy,
                       input logic [NS-1:0] rdv, input logic [NS*DW-1:0] rdat);
    bus.addr = a; bus.write_req = wr; bus.read_req = rd; bus.s_ready = srdy;
    bus.s_read_data_valid = rdv; bus.s_read_data = rdat;
    bus.write_data = 32'h5A5A_0000 | a[15:0]; bus.byte_enable = a[3:0] | 4'h1;
  endtask

  task automatic idle(input logic [NS-1:0] rdv, input logic [NS*DW-1:0] rdat);
    drive(32'h0000_0000, 1'b0, 1'b0, 4'hF, rdv, rdat);
  endtask

  task automatic settle_check();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(32'h1000_0000, 1'b0, 1'b1, 4'hF, 4'h1, 128'h0);
    settle_check();
    chk("rst_ready", bus.ready, 1'b0);
    chk("rst_read_data_valid", bus.read_data_valid, 1'b0);
    chk("rst_s_read_req", bus.s_read_req, 4'h0);
    advance();
    reset_n = 1'b1;
    idle(4'h0, 128'h0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0]   addr;
    logic          wr;
    logic          rd;
    logic [NS-1:0] srdy;
    logic          exp_ready;
    logic [NS-1:0] exp_wstb;
    logic [NS-1:0] exp_rstb;
    logic          exp_de;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] a;
    logic [3:0]  tg;
    logic [NS-1:0] rdv;
    int v;

    vecs[0] = '{32'h1000_0010, 1'b0, 1'b1, 4'hF, 1'b1, 4'h0, 4'h1, 1'b0};
    vecs[1] = '{32'h2000_0000, 1'b1, 1'b0, 4'hF, 1'b1, 4'h2, 4'h0, 1'b0};
    vecs[2] = '{32'h3000_0004, 1'b0, 1'b1, 4'hB, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[3] = '{32'h3000_0004, 1'b0, 1'b1, 4'hF, 1'b1, 4'h0, 4'h4, 1'b0};
    vecs[4] = '{32'h4000_0000, 1'b1, 1'b1, 4'hF, 1'b1, 4'h8, 4'h0, 1'b0};
    vecs[5] = '{32'h0000_0000, 1'b0, 1'b1, 4'hF, 1'b1, 4'h0, 4'h0, 1'b1};
    vecs[6] = '{32'hF000_0000, 1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b1};
    vecs[7] = '{32'h1FFF_FFFF, 1'b0, 1'b0, 4'hE, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[8] = '{32'h5000_0000, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0};
    vecs[9] = '{32'h2000_0000, 1'b0, 1'b1, 4'hD, 1'b0, 4'h0, 4'h0, 1'b0};

    idle(4'h0, 128'h0);
    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].srdy, 4'h0, 128'h0);
      settle_check();
      chk($sformatf("vec%0d_ready", i), bus.ready, vecs[i].exp_ready);
      chk($sformatf("vec%0d_s_write_req", i), bus.s_write_req, vecs[i].exp_wstb);
      chk($sformatf("vec%0d_s_read_req", i), bus.s_read_req, vecs[i].exp_rstb);
      chk($sformatf("vec%0d_decode_error", i), bus.decode_error, vecs[i].exp_de);
      advance();
      do_reset();
    end

    // Slave 0 read returning three cycles after acceptance
    drive(32'h1000_0040, 1'b0, 1'b1, 4'hF, 4'h0, 128'h0);
    settle_check(); chk("s32_rstb", bus.s_read_req, 4'h1); advance();
    for (int i = 0; i < 2; i++) begin
      idle(4'h0, 128'h0); settle_check(); chk("s32_wait_rdv", bus.read_data_valid, 1'b0); advance();
    end
    idle(4'h1, {96'h0, 32'hDEADBEEF});
    settle_check();
    chk("s32_rdv", bus.read_data_valid, 1'b1);
    chk("s32_data", bus.read_data, 32'hDEADBEEF);
    advance();
    idle(4'h0, {96'h0, 32'hDEADBEEF});
    settle_check();
    chk("s32_rdv_after", bus.read_data_valid, 1'b0);
    chk("s32_data_after", bus.read_data, 32'h0);
    advance();

    // Unmapped read: decode error on accept, fixed data one cycle later
    drive(32'h0000_0000, 1'b0, 1'b1, 4'hF, 4'h0, 128'h0);
    settle_check();
    chk("s33_decode_error", bus.decode_error, 1'b1);
    chk("s33_rdv_accept", bus.read_data_valid, 1'b0);
    advance();
    idle(4'h0, 128'h0);
    settle_check();
    chk("s33_rdv", bus.read_data_valid, 1'b1);
    chk("s33_data", bus.read_data, UNMAP);
    chk("s33_de_after", bus.decode_error, 1'b0);
    advance();
    idle(4'h0, 128'h0); settle_check(); chk("s33_rdv_done", bus.read_data_valid, 1'b0); advance();

    // Out-of-order return from slave 1 is discarded and flagged
    drive(32'h1000_0000, 1'b0, 1'b1, 4'hF, 4'h0, 128'h0); settle_check(); advance();
    drive(32'h2000_0000, 1'b0, 1'b1, 4'hF, 4'h0, 128'h0); settle_check(); advance();
    idle(4'h2, {64'h0, 32'h1111_1111, 32'h0});
    settle_check();
    chk("s34_stray_rdv", bus.read_data_valid, 1'b0);
    chk("s34_stray_before", bus.stray_response, 1'b0);
    advance();
    idle(4'h1, {96'h0, 32'h2222_2222});
    settle_check();
    chk("s34_stray_set", bus.stray_response, 1'b1);
    chk("s34_s0_rdv", bus.read_data_valid, 1'b1);
    chk("s34_s0_data", bus.read_data, 32'h2222_2222);
    advance();
    idle(4'h2, {64'h0, 32'h3333_3333, 32'h0});
    settle_check();
    chk("s34_s1_rdv", bus.read_data_valid, 1'b1);
    chk("s34_s1_data", bus.read_data, 32'h3333_3333);
    advance();

    // Tracking full: fifth read stalls, pop in same cycle does not free it until next cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(32'h1000_0100, 1'b0, 1'b1, 4'hF, 4'h0, 128'h0);
      settle_check(); chk("s35_fill_ready", bus.ready, 1'b1); advance();
    end
    drive(32'h1000_0100, 1'b0, 1'b1, 4'hF, 4'h0, 128'h0);
    settle_check(); chk("s35_full_ready", bus.ready, 1'b0); chk("s35_full_rstb", bus.s_read_req, 4'h0); advance();
    drive(32'h1000_0100, 1'b0, 1'b1, 4'hF, 4'h1, {96'h0, 32'h5555_5555});
    settle_check(); chk("s35_pop_ready", bus.ready, 1'b0); chk("s35_pop_rdv", bus.read_data_valid, 1'b1); advance();
    drive(32'h1000_0100, 1'b0, 1'b1, 4'hF, 4'h0, 128'h0);
    settle_check(); chk("s35_next_ready", bus.ready, 1'b1); chk("s35_next_rstb", bus.s_read_req, 4'h1); advance();
    for (int i = 0; i < 4; i++) begin
      idle(4'h1, {96'h0, 32'h6000_0000 + i});
      settle_check(); chk("s35_drain_rdv", bus.read_data_valid, 1'b1); advance();
    end

    // Reset with reads outstanding; late return becomes stray
    do_reset();
    idle(4'h0, 128'h0); settle_check(); chk("s37_stray_cleared", bus.stray_response, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(32'h2000_0000, 1'b0, 1'b1, 4'hF, 4'h0, 128'h0); settle_check(); advance();
    end
    do_reset();
    drive(32'h2000_0000, 1'b0, 1'b0, 4'hF, 4'h0, 128'h0);
    settle_check(); chk("s37_ready_after_reset", bus.ready, 1'b1); advance();
    idle(4'h2, {64'h0, 32'h7777_7777, 32'h0});
    settle_check(); chk("s37_late_rdv", bus.read_data_valid, 1'b0); advance();
    idle(4'h0, 128'h0);
    settle_check(); chk("s37_late_stray", bus.stray_response, 1'b1); advance();

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      v  = $urandom_range(0, 6);
      tg = (v == 6) ? 4'hF : 4'(v);
      a  = {tg, 28'($urandom)};
      rdv = '0;
      if (q.size() > 0 && q[0] < NS && $urandom_range(0, 2) == 0) rdv[q[0]] = 1'b1;
      if ($urandom_range(0, 24) == 0) rdv[$urandom_range(0, NS - 1)] = 1'b1;
      reset_n = ($urandom_range(0, 199) != 0);
      drive(a, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0),
            4'($urandom) | 4'($urandom), rdv,
            {$urandom(), $urandom(), $urandom(), $urandom()});
      settle_check();
      advance();
    end
    reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
